// File: rtl/parity_step_counter.sv
// parity_step_counter: ODD / EVEN / programmable-STEP up/down counter with synchronous load,
// elaboration-time wrap-or-saturate range handling and terminal-count, saturation and error flags.
module parity_step_counter #(
   parameter int WIDTH   = 8,
   parameter int STEP_W  = 4,
   parameter bit WRAP_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [1:0]        mode_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              load_i,
   input  logic [WIDTH-1:0]  load_val_i,
   output logic [WIDTH-1:0]  cnt_o,
   output logic              tc_o,
   output logic              sat_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      MODE_ODD  = 2'b00,
      MODE_EVEN = 2'b01,
      MODE_STEP = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] EVEN_TOP = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH:0]   TWO_EXT  = {{(WIDTH-1){1'b0}}, 2'b10};

   // Parity helpers: ODD wants LSB=1, EVEN wants LSB=0.
   function automatic logic parity_ok(input logic [WIDTH-1:0] v, input logic want_odd);
      return (v[0] == want_odd);
   endfunction

   function automatic logic [WIDTH-1:0] parity_align(input logic [WIDTH-1:0] v, input logic want_odd);
      return {v[WIDTH-1:1], want_odd};
   endfunction

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             sat_q, sat_d;
   logic             err_q, err_d;

   mode_e            mode_s;
   logic             parity_mode_s;
   logic             want_odd_s;
   logic             illegal_s;
   logic [WIDTH:0]   step_ext_s;
   logic [WIDTH:0]   sum_s;
   logic             range_hit_s;
   logic [WIDTH-1:0] bound_s;

   // Mode decode, WIDTH+1-bit step arithmetic and clamp bound selection.
   always_comb begin
      mode_s        = mode_e'(mode_i);
      parity_mode_s = 1'b0;
      want_odd_s    = 1'b0;
      illegal_s     = 1'b0;
      step_ext_s    = TWO_EXT;
      case (mode_s)
         MODE_ODD: begin
            parity_mode_s = 1'b1;
            want_odd_s    = 1'b1;
         end
         MODE_EVEN: begin
            parity_mode_s = 1'b1;
            want_odd_s    = 1'b0;
         end
         MODE_STEP: begin
            step_ext_s = {{(WIDTH+1-STEP_W){1'b0}}, step_i};
            illegal_s  = (step_i == {STEP_W{1'b0}});
         end
         default: begin
            illegal_s = 1'b1;
         end
      endcase

      if (dir_i) begin
         sum_s = {1'b0, cnt_q} - step_ext_s;
      end else begin
         sum_s = {1'b0, cnt_q} + step_ext_s;
      end
      // The extra bit is the carry going up and the borrow going down.
      range_hit_s = sum_s[WIDTH];

      if (dir_i) begin
         bound_s = (mode_s == MODE_ODD) ? ONE_VAL : ZERO_VAL;
      end else begin
         bound_s = (mode_s == MODE_EVEN) ? EVEN_TOP : ALL_ONES;
      end
   end

   // Next-state selection: load > enabled step > hold (reset handled in the flop block).
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      sat_d = sat_q;
      err_d = err_q;
      if (load_i) begin
         cnt_d = load_val_i;
         sat_d = 1'b0;
      end else if (en_i) begin
         if (illegal_s) begin
            err_d = 1'b1;
         end else if (parity_mode_s && !parity_ok(cnt_q, want_odd_s)) begin
            cnt_d = parity_align(cnt_q, want_odd_s);
            sat_d = 1'b0;
         end else if (!range_hit_s) begin
            cnt_d = sum_s[WIDTH-1:0];
            sat_d = 1'b0;
         end else if (WRAP_EN) begin
            cnt_d = sum_s[WIDTH-1:0];
            tc_d  = 1'b1;
         end else begin
            // tc only marks entry into the clamp, not each repeated clamp.
            cnt_d = bound_s;
            tc_d  = !sat_q;
            sat_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and flag registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= ZERO_VAL;
         tc_q  <= 1'b0;
         sat_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         sat_q <= sat_d;
         err_q <= err_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = tc_q;
   assign sat_o = sat_q;
   assign err_o = err_q;

endmodule

// File: tb/tb_parity_step_counter.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and are
// compared every cycle against an integer reference model, plus directed scenario checks.
module tb_parity_step_counter;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;
   localparam int MAXV   = 256;

   localparam logic [1:0] ODD  = 2'd0;
   localparam logic [1:0] EVEN = 2'd1;
   localparam logic [1:0] STP  = 2'd2;
   localparam logic [1:0] RSVD = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, en_i, dir_i, load_i;
   logic [1:0]        mode_i;
   logic [STEP_W-1:0] step_i;
   logic [WIDTH-1:0]  load_val_i;

   logic [WIDTH-1:0] cnt_w, cnt_s;
   logic             tc_w, sat_w, err_w, tc_s, sat_s, err_s;

   int checks = 0;
   int errors = 0;

   // index 0 = wrapping instance, index 1 = saturating instance
   int m_cnt[2], m_tc[2], m_sat[2], m_err[2];

   parity_step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .WRAP_EN(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .dir_i(dir_i), .step_i(step_i),
      .load_i(load_i), .load_val_i(load_val_i),
      .cnt_o(cnt_w), .tc_o(tc_w), .sat_o(sat_w), .err_o(err_w)
   );

   parity_step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .WRAP_EN(1'b0)) dut_sat (
      .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .dir_i(dir_i), .step_i(step_i),
      .load_i(load_i), .load_val_i(load_val_i),
      .cnt_o(cnt_s), .tc_o(tc_s), .sat_o(sat_s), .err_o(err_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: one edge of the counting rules, on plain integers.
   task automatic model_step();
      int s, n;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_cnt[k] = 0; m_tc[k] = 0; m_sat[k] = 0; m_err[k] = 0;
         end else if (load_i) begin
            m_cnt[k] = int'(load_val_i); m_tc[k] = 0; m_sat[k] = 0;
         end else if (!en_i) begin
            m_tc[k] = 0;
         end else if (mode_i == RSVD || (mode_i == STP && step_i == 0)) begin
            m_err[k] = 1; m_tc[k] = 0;
         end else if (mode_i == ODD && m_cnt[k] % 2 == 0) begin
            m_cnt[k] = m_cnt[k] + 1; m_tc[k] = 0; m_sat[k] = 0;
         end else if (mode_i == EVEN && m_cnt[k] % 2 == 1) begin
            m_cnt[k] = m_cnt[k] - 1; m_tc[k] = 0; m_sat[k] = 0;
         end else begin
            s = (mode_i == STP) ? int'(step_i) : 2;
            n = dir_i ? m_cnt[k] - s : m_cnt[k] + s;
            if (n >= 0 && n < MAXV) begin
               m_cnt[k] = n; m_tc[k] = 0; m_sat[k] = 0;
            end else if (k == 0) begin
               m_cnt[k] = (n + MAXV) % MAXV; m_tc[k] = 1;
            end else begin
               if (dir_i) m_cnt[k] = (mode_i == ODD) ? 1 : 0;
               else       m_cnt[k] = (mode_i == EVEN) ? MAXV - 2 : MAXV - 1;
               m_tc[k]  = (m_sat[k] == 0) ? 1 : 0;
               m_sat[k] = 1;
            end
         end
      end
   endtask

   task automatic do_cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".w.cnt"}, 32'(cnt_w), m_cnt[0]);
      chk({tag, ".w.tc"},  32'(tc_w),  m_tc[0]);
      chk({tag, ".w.sat"}, 32'(sat_w), m_sat[0]);
      chk({tag, ".w.err"}, 32'(err_w), m_err[0]);
      chk({tag, ".s.cnt"}, 32'(cnt_s), m_cnt[1]);
      chk({tag, ".s.tc"},  32'(tc_s),  m_tc[1]);
      chk({tag, ".s.sat"}, 32'(sat_s), m_sat[1]);
      chk({tag, ".s.err"}, 32'(err_s), m_err[1]);
   endtask

   task automatic drive(input logic r, input logic l, input int lv, input logic e,
                        input logic [1:0] m, input logic d, input int s, input string tag);
      rst        = r;
      load_i     = l;
      load_val_i = WIDTH'(lv);
      en_i       = e;
      mode_i     = m;
      dir_i      = d;
      step_i     = STEP_W'(s);
      do_cycle(tag);
   endtask

   initial begin
      // 1: reset, then ODD up through the wrap
      drive(1'b1, 1'b0, 0, 1'b0, ODD, 1'b0, 0, "t1.rst");
      chk("t1.rst.cnt", 32'(cnt_w), 32'd0);
      chk("t1.rst.flags", {29'd0, tc_s, sat_s, err_s}, 32'd0);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t1.align");
      chk("t1.align.cnt", 32'(cnt_w), 32'd1);
      for (int i = 0; i < 127; i++) drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t1.run");
      chk("t1.top", 32'(cnt_w), 32'd255);
      chk("t1.top.tc", 32'(tc_w), 32'd0);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t1.wrap");
      chk("t1.wrap.cnt", 32'(cnt_w), 32'd1);
      chk("t1.wrap.tc", 32'(tc_w), 32'd1);
      chk("t1.clamp.cnt", 32'(cnt_s), 32'd255);
      chk("t1.clamp.sat", 32'(sat_s), 32'd1);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t1.after");
      chk("t1.after.cnt", 32'(cnt_w), 32'd3);
      chk("t1.after.tc", 32'(tc_w), 32'd0);
      chk("t1.hold.tc", 32'(tc_s), 32'd0);

      // 2: reset mid-count overrides load and enable
      drive(1'b1, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t2.rst");
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t2.run");
      chk("t2.seven", 32'(cnt_w), 32'd7);
      drive(1'b1, 1'b1, 100, 1'b1, ODD, 1'b0, 0, "t2.rstld");
      chk("t2.rstld.cnt", 32'(cnt_w), 32'd0);
      chk("t2.rstld.flags", {29'd0, tc_w, sat_w, err_w}, 32'd0);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t2.r1");
      chk("t2.r1.cnt", 32'(cnt_w), 32'd1);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t2.r3");
      chk("t2.r3.cnt", 32'(cnt_w), 32'd3);

      // 3: EVEN down from a loaded odd value, through the low end
      drive(1'b0, 1'b1, 5, 1'b0, EVEN, 1'b1, 0, "t3.load");
      chk("t3.load.cnt", 32'(cnt_w), 32'd5);
      drive(1'b0, 1'b0, 0, 1'b1, EVEN, 1'b1, 0, "t3.align");
      chk("t3.align.cnt", 32'(cnt_w), 32'd4);
      drive(1'b0, 1'b0, 0, 1'b1, EVEN, 1'b1, 0, "t3.two");
      drive(1'b0, 1'b0, 0, 1'b1, EVEN, 1'b1, 0, "t3.zero");
      chk("t3.zero.cnt", 32'(cnt_w), 32'd0);
      drive(1'b0, 1'b0, 0, 1'b1, EVEN, 1'b1, 0, "t3.wrap");
      chk("t3.wrap.cnt", 32'(cnt_w), 32'd254);
      chk("t3.wrap.tc", 32'(tc_w), 32'd1);
      chk("t3.clamp.cnt", 32'(cnt_s), 32'd0);
      chk("t3.clamp.tc", 32'(tc_s), 32'd1);
      drive(1'b0, 1'b0, 0, 1'b1, EVEN, 1'b1, 0, "t3.next");
      chk("t3.next.cnt", 32'(cnt_w), 32'd252);
      chk("t3.hold.sat", 32'(sat_s), 32'd1);

      // 4: STEP=3 up into the top bound, then back down
      drive(1'b0, 1'b1, 250, 1'b0, STP, 1'b0, 3, "t4.load");
      drive(1'b0, 1'b0, 0, 1'b1, STP, 1'b0, 3, "t4.s1");
      chk("t4.s1.cnt", 32'(cnt_s), 32'd253);
      drive(1'b0, 1'b0, 0, 1'b1, STP, 1'b0, 3, "t4.clamp");
      chk("t4.clamp.cnt", 32'(cnt_s), 32'd255);
      chk("t4.clamp.tcsat", {30'd0, tc_s, sat_s}, 32'd3);
      drive(1'b0, 1'b0, 0, 1'b1, STP, 1'b0, 3, "t4.hold");
      chk("t4.hold.tcsat", {30'd0, tc_s, sat_s}, 32'd1);
      drive(1'b0, 1'b0, 0, 1'b1, STP, 1'b1, 3, "t4.down");
      chk("t4.down.cnt", 32'(cnt_s), 32'd252);
      chk("t4.down.sat", 32'(sat_s), 32'd0);

      // 5: illegal mode and zero step set the sticky error
      drive(1'b0, 1'b0, 0, 1'b1, RSVD, 1'b0, 3, "t5.rsvd");
      chk("t5.rsvd.cnt", 32'(cnt_s), 32'd252);
      chk("t5.rsvd.err", 32'(err_s), 32'd1);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t5.odd");
      chk("t5.odd.cnt", 32'(cnt_s), 32'd253);
      drive(1'b0, 1'b0, 0, 1'b1, ODD, 1'b0, 0, "t5.odd2");
      chk("t5.odd2.err", 32'(err_w), 32'd1);
      drive(1'b1, 1'b0, 0, 1'b0, ODD, 1'b0, 0, "t5.rst");
      chk("t5.rst.err", 32'(err_w), 32'd0);
      drive(1'b0, 1'b0, 0, 1'b1, STP, 1'b0, 0, "t5.zstep");
      chk("t5.zstep.cnt", 32'(cnt_w), 32'd0);
      chk("t5.zstep.err", 32'(err_w), 32'd1);

      // 6: load beats enable and is not parity-aligned; idle holds
      drive(1'b0, 1'b1, 8'h40, 1'b1, ODD, 1'b0, 0, "t6.load");
      chk("t6.load.cnt", 32'(cnt_w), 32'h40);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 0, 1'b0, ODD, 1'b0, 0, "t6.idle");
         chk("t6.idle.cnt", 32'(cnt_w), 32'h40);
         chk("t6.idle.tc", 32'(tc_w), 32'd0);
      end

      // 7: randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(63, 0) == 0), ($urandom_range(7, 0) == 0),
               int'($urandom_range(255, 0)), ($urandom_range(3, 0) != 0),
               2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               int'($urandom_range(15, 0)), "t7.rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
